// File: rtl/sr_round_unit_pkg.sv
// sr_pkg: shared widths, pipeline payload structs and rounding helpers for sr_round_unit
package sr_pkg;
  localparam int SR_MANT_IN_W = 48;
  localparam int SR_MANT_OUT_W = 24;
  localparam int SR_EXP_W = 8;
  localparam int SR_NUM_ROUND_BITS = 8;
  typedef struct packed {
    logic                     sign;
    logic [SR_EXP_W-1:0]      exp;
    logic [SR_MANT_OUT_W-1:0] kept;
    logic                     inc;
    logic                     inexact;
    logic                     special;
  } sr_s1_t;
  typedef struct packed {
    logic                     sign;
    logic [SR_EXP_W-1:0]      exp;
    logic [SR_MANT_OUT_W-1:0] mant;
    logic                     inexact;
    logic                     overflow;
  } sr_res_t;
  function automatic logic exp_all_ones(input logic [SR_EXP_W-1:0] e);
    return &e;
  endfunction
  function automatic logic round_inc(input logic [SR_NUM_ROUND_BITS-1:0] rbits, input logic [SR_NUM_ROUND_BITS-1:0] rng);
    logic [SR_NUM_ROUND_BITS:0] s;
    s = {1'b0, rbits} + {1'b0, rng};
    return s[SR_NUM_ROUND_BITS];
  endfunction
endpackage

// File: rtl/sr_round_unit_if.sv
// sr_round_unit_if: operand/result valid-ready buses plus RNG pull port
//   slave  : the rounding unit (consumes operands and RNG words, produces results)
//   master : the environment (drives operands, supplies RNG, accepts results)
interface sr_round_unit_if import sr_pkg::*; ();
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_sign;
  logic [SR_EXP_W-1:0]          in_exp;
  logic [SR_MANT_IN_W-1:0]      in_mant;
  logic                         rng_get_next_val;
  logic [SR_NUM_ROUND_BITS-1:0] rng_val;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_sign;
  logic [SR_EXP_W-1:0]          out_exp;
  logic [SR_MANT_OUT_W-1:0]     out_mant;
  logic                         out_inexact;
  logic                         out_overflow;
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, rng_val, out_ready,
    output in_ready, rng_get_next_val, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
  );
  modport master (
    output in_valid, in_sign, in_exp, in_mant, rng_val, out_ready,
    input  in_ready, rng_get_next_val, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
  );
endinterface

// File: rtl/sr_round_unit_pipe_reg.sv
// sr_pipe_reg: one valid/ready register slice; data holds while stalled
//   i_valid/o_ready/i_data : upstream side
//   o_valid/i_ready/o_data : downstream side
module sr_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign o_ready = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data = r_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
endmodule

// File: rtl/sr_round_unit.sv
// sr_round_unit: stochastic rounding of a wide mantissa through a 2-stage elastic pipe
//   clk, resetn : clock, async active-low reset
//   bus (slave) : operand in, one RNG word pulled per accepted operand, rounded result out
module sr_round_unit import sr_pkg::*; #(
  parameter int MANT_IN_W = SR_MANT_IN_W,
  parameter int MANT_OUT_W = SR_MANT_OUT_W,
  parameter int EXP_W = SR_EXP_W,
  parameter int NUM_ROUND_BITS = SR_NUM_ROUND_BITS
) (
  input logic clk,
  input logic resetn,
  sr_round_unit_if.slave bus
);
  localparam int LOW_W = MANT_IN_W - MANT_OUT_W;
  sr_s1_t              w_s1_d, w_s1_q;
  sr_res_t             w_s2_d, w_s2_q;
  logic                w_s1_valid, w_s2_ready, w_special;
  logic [MANT_OUT_W:0] w_m;
  logic [EXP_W-1:0]    w_exp;
  assign w_special = exp_all_ones(bus.in_exp);
  // the RNG word is consumed exactly on acceptance, specials included, to keep the stream aligned
  assign bus.rng_get_next_val = bus.in_valid & bus.in_ready;
  always_comb begin
    w_s1_d.sign = bus.in_sign;
    w_s1_d.exp = bus.in_exp;
    w_s1_d.kept = bus.in_mant[MANT_IN_W-1 -: MANT_OUT_W];
    w_s1_d.inc = ~w_special & round_inc(bus.in_mant[LOW_W-1 -: NUM_ROUND_BITS], bus.rng_val);
    w_s1_d.inexact = ~w_special & (|bus.in_mant[LOW_W-1:0]);
    w_s1_d.special = w_special;
  end
  sr_pipe_reg #(.W($bits(sr_s1_t))) u_s1 (
    .clk(clk), .resetn(resetn),
    .i_valid(bus.in_valid), .o_ready(bus.in_ready), .i_data(w_s1_d),
    .o_valid(w_s1_valid), .i_ready(w_s2_ready), .o_data(w_s1_q)
  );
  assign w_m = {1'b0, w_s1_q.kept} + (MANT_OUT_W+1)'(w_s1_q.inc);
  // carry renormalizes; a subnormal whose increment reaches the hidden bit becomes exp 1
  always_comb begin
    w_exp = w_m[MANT_OUT_W] ? w_s1_q.exp + 1'b1 :
            (w_s1_q.exp == '0 && w_m[MANT_OUT_W-1] && !w_s1_q.kept[MANT_OUT_W-1]) ? EXP_W'(1) : w_s1_q.exp;
    w_s2_d.sign = w_s1_q.sign;
    w_s2_d.exp = w_exp;
    w_s2_d.inexact = w_s1_q.inexact;
    w_s2_d.overflow = ~w_s1_q.special & exp_all_ones(w_exp);
    w_s2_d.mant = w_s2_d.overflow ? '0 :
                  w_m[MANT_OUT_W] ? MANT_OUT_W'(1) << (MANT_OUT_W-1) : w_m[MANT_OUT_W-1:0];
  end
  sr_pipe_reg #(.W($bits(sr_res_t))) u_s2 (
    .clk(clk), .resetn(resetn),
    .i_valid(w_s1_valid), .o_ready(w_s2_ready), .i_data(w_s2_d),
    .o_valid(bus.out_valid), .i_ready(bus.out_ready), .o_data(w_s2_q)
  );
  assign bus.out_sign = w_s2_q.sign;
  assign bus.out_exp = w_s2_q.exp;
  assign bus.out_mant = w_s2_q.mant;
  assign bus.out_inexact = w_s2_q.inexact;
  assign bus.out_overflow = w_s2_q.overflow;
endmodule

// File: tb/tb_sr_round_unit.sv
// tb_sr_round_unit: directed + randomized checks of sr_round_unit against an arithmetic model
module tb_sr_round_unit;
  import sr_pkg::*;
  typedef struct {sr_res_t r; int id;} exp_t;
  logic clk = 0;
  logic resetn = 0;
  sr_round_unit_if bus();
  sr_round_unit dut (.clk(clk), .resetn(resetn), .bus(bus));
  exp_t q[$];
  int compared = 0, mismatched = 0, pulses = 0, nid = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (resetn && bus.rng_get_next_val) pulses++;
  function automatic sr_res_t model(input logic s, input logic [7:0] e, input logic [47:0] m, input logic [7:0] rv);
    int unsigned kept, rb, k2, ex;
    sr_res_t r;
    kept = m[47:24];
    rb = m[23:16];
    ex = e;
    r.sign = s;
    if (e == 8'hFF) begin
      r.exp = e; r.mant = kept[23:0]; r.inexact = 1'b0; r.overflow = 1'b0;
      return r;
    end
    k2 = kept + ((rb + rv >= 256) ? 1 : 0);
    if (k2 == 32'h100_0000) begin k2 = 32'h80_0000; ex = ex + 1; end
    else if (e == 0 && k2 >= 32'h80_0000 && kept < 32'h80_0000) ex = 1;
    r.inexact = m[23:0] != 0;
    r.overflow = ex == 255;
    r.exp = ex[7:0];
    r.mant = r.overflow ? 24'h0 : k2[23:0];
    return r;
  endfunction
  function automatic sr_res_t mk(input logic s, input logic [7:0] e, input logic [23:0] m, input logic ix, input logic ov);
    sr_res_t r;
    r.sign = s; r.exp = e; r.mant = m; r.inexact = ix; r.overflow = ov;
    return r;
  endfunction
  always @(negedge clk) if (resetn && bus.out_valid && bus.out_ready) begin
    sr_res_t o;
    exp_t x;
    o = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow};
    compared++;
    assert (q.size() != 0) else begin mismatched++; $error("FAIL unexpected_out obs=%h exp=none", o); end
    if (q.size() != 0) begin
      x = q.pop_front();
      compared++;
      assert (o === x.r) else begin mismatched++; $error("FAIL out#%0d obs=%h exp=%h", x.id, o, x.r); end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin mismatched++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv); end
  endtask
  task automatic drive(input logic s, input logic [7:0] e, input logic [47:0] m, input logic [7:0] rv);
    bus.in_valid = 1; bus.in_sign = s; bus.in_exp = e; bus.in_mant = m; bus.rng_val = rv;
  endtask
  task automatic send(input logic s, input logic [7:0] e, input logic [47:0] m, input logic [7:0] rv,
                      input bit given, input sr_res_t gr, input bit rnd_rdy);
    int n = 0;
    bit ok = 0;
    drive(s, e, m, rv);
    while (!ok && n < 100) begin
      if (rnd_rdy) bus.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) begin
        q.push_back('{given ? gr : model(s, e, m, rv), nid});
        nid++;
        chk("rng_pulse", 64'(bus.rng_get_next_val), 64'd1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask
  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic drain();
    int n = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  sr_res_t none;
  initial begin
    logic [7:0] re[6], rr[6];
    logic [47:0] rm[6];
    logic hold_s;
    logic [7:0] hold_e;
    logic [23:0] hold_m;
    int p;
    none = '0;
    bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = 0; bus.in_mant = 0; bus.rng_val = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_fields", {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow}, 64'd0);
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rng_idle", 64'(bus.rng_get_next_val), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1;
    p = pulses;
    send(0, 8'h40, {24'h800000, 8'h80, 16'h0}, 8'h7F, 1, mk(0, 8'h40, 24'h800000, 1, 0), 0);
    send(0, 8'h40, {24'h800000, 8'h80, 16'h0}, 8'h80, 1, mk(0, 8'h40, 24'h800001, 1, 0), 0);
    send(1, 8'h10, {24'hFFFFFF, 8'hFF, 16'h0}, 8'h01, 1, mk(1, 8'h11, 24'h800000, 1, 0), 0);
    send(0, 8'hFE, {24'hFFFFFF, 8'hFF, 16'h0}, 8'hFF, 1, mk(0, 8'hFF, 24'h000000, 1, 1), 0);
    send(0, 8'h40, {24'hABCDEF, 24'h0}, 8'hFF, 1, mk(0, 8'h40, 24'hABCDEF, 0, 0), 0);
    send(0, 8'h00, {24'h7FFFFF, 8'hFF, 16'h0}, 8'h01, 1, mk(0, 8'h01, 24'h800000, 1, 0), 0);
    idle(2);
    chk("directed_pulses", 64'(pulses - p), 64'd6);
    p = pulses;
    send(1, 8'hFF, {24'hC00000, 24'h123456}, 8'hFF, 1, mk(1, 8'hFF, 24'hC00000, 0, 0), 0);
    idle(2);
    chk("nan_pulses", 64'(pulses - p), 64'd1);
    drain();
    for (int i = 0; i < 6; i++) begin
      re[i] = 8'($urandom_range(1, 254)); rr[i] = 8'($urandom); rm[i] = {16'($urandom), $urandom};
    end
    p = pulses;
    bus.out_ready = 0;
    send(0, re[0], rm[0], rr[0], 0, none, 0);
    send(1, re[1], rm[1], rr[1], 0, none, 0);
    drive(0, re[2], rm[2], rr[2]);
    @(negedge clk);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_no_pull", 64'(bus.rng_get_next_val), 64'd0);
    hold_s = bus.out_sign; hold_e = bus.out_exp; hold_m = bus.out_mant;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_in_ready_hold", 64'(bus.in_ready), 64'd0);
    chk("bp_stable", {bus.out_sign, bus.out_exp, bus.out_mant}, {hold_s, hold_e, hold_m});
    @(posedge clk); #1;
    bus.out_ready = 1;
    for (int i = 2; i < 6; i++) send(i[0], re[i], rm[i], rr[i], 0, none, 0);
    drain();
    chk("bp_pulses", 64'(pulses - p), 64'd6);
    send(0, re[0], rm[0], rr[0], 0, none, 0);
    send(1, re[1], rm[1], rr[1], 0, none, 0);
    bus.in_valid = 0;
    resetn = 0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    resetn = 1;
    idle(5);
    chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
    p = pulses;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] e;
      logic [47:0] m;
      case ($urandom_range(0, 7))
        0: e = 8'h00;
        1: e = 8'hFE;
        2: e = 8'hFF;
        3: e = 8'h01;
        default: e = 8'($urandom);
      endcase
      m = {16'($urandom), $urandom};
      if ($urandom_range(0, 5) == 0) m[23:0] = 24'h0;
      if ($urandom_range(0, 5) == 0) m[47:24] = 24'hFFFFFF;
      send(1'($urandom), e, m, 8'($urandom), 0, none, 1);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("rand_pulses", 64'(pulses - p), 64'd300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sr_round_unit.md
# sr_round_unit

Stochastic-rounding back end for the FPU datapath. It is the consumer side of the round-bit RNG interface. It accepts a normalized wide-mantissa result over a valid/ready handshake and pulls exactly one random word per accepted operand by pulsing `rng_get_next_val`. It adds that word to the top discarded bits, truncates to the output precision, renormalizes, and delivers the rounded result through a 2-stage elastic pipeline.

## Interface
- `MANT_IN_W`, 48: wide mantissa width. Bit `MANT_IN_W-1` is the explicit hidden bit.
- `MANT_OUT_W`, 24: rounded mantissa width, including the explicit hidden bit.
- `EXP_W`, 8: biased exponent width.
- `NUM_ROUND_BITS`, 8: random word width. Must satisfy `NUM_ROUND_BITS <= MANT_IN_W-MANT_OUT_W`.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: operand handshake.
- `in_sign` in 1, `in_exp` in `EXP_W`, `in_mant` in `MANT_IN_W`: operand fields.
- `rng_get_next_val` out 1: advances the RNG at the next clock edge.
- `rng_val` in `NUM_ROUND_BITS`: current RNG output, combinational from RNG state.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `out_sign` out 1, `out_exp` out `EXP_W`, `out_mant` out `MANT_OUT_W`: result fields.
- `out_inexact` out 1: at least one discarded bit was nonzero.
- `out_overflow` out 1: rounding carried the exponent to all-ones.

## Operation
- Accept: an operand is accepted when `in_valid & in_ready` at a clock edge.
- RNG handshake:
  - `rng_get_next_val = in_valid & in_ready`, combinational.
  - `rng_val` is sampled in that same cycle, so each accepted operand consumes exactly one fresh word.
  - No word is consumed at any other time.
  - Special operands also consume a word, which keeps the random stream aligned with the operand count.
- Fields:
  - `kept = in_mant[MANT_IN_W-1 -: MANT_OUT_W]`.
  - `rbits = in_mant[MANT_IN_W-MANT_OUT_W-1 -: NUM_ROUND_BITS]`.
  - Bits below `rbits` affect only `inexact`.
- Increment: `inc = carry-out of (rbits + rng_val)`, computed at `NUM_ROUND_BITS+1` bits, i.e. `rbits + rng_val >= 2^NUM_ROUND_BITS`.
- Mantissa update: `m = kept + inc`, computed at `MANT_OUT_W+1` bits.
  - If `m` overflows: `out_mant = 1<<(MANT_OUT_W-1)` and `exp = in_exp+1`.
  - If `in_exp == 0` and the increment sets the hidden bit (subnormal promotion): `exp = 1`.
- Exponent overflow: if the resulting exp is all-ones, `out_exp` = all-ones, `out_mant = 0`, `out_overflow = 1`.
- Special pass-through: if `in_exp` is all-ones (Inf/NaN), the output equals the input truncated to `kept`, with `inc` forced to 0, `inexact = 0` and `overflow = 0`.
- `out_inexact = |in_mant[MANT_IN_W-MANT_OUT_W-1:0]`, for non-special operands.

## Timing
- Pipeline:
  - S1 registers the operand, `rng_val`, `inc` and `inexact`.
  - S2 registers the final result.
  - Latency is 2 cycles from acceptance to `out_valid`. Throughput is 1 per cycle.
- Ready chain:
  - `s2_ready = ~s2_valid | out_ready`.
  - `in_ready = ~s1_valid | s2_ready`.
  - No combinational path from `in_valid` to `in_ready`.
- Backpressure: with `out_ready` low, at most 2 operands are held and `in_ready` drops. Ordering is strictly preserved.
- AXI-style output: once `out_valid` is high, the result fields are stable until `out_ready`.
- Simultaneous events: accept and drain in the same cycle on a full pipe is legal and loses nothing.
- Reset values: all valid flags 0; all output data fields 0; `out_inexact = out_overflow = 0`.
  - `in_ready` is 1 after reset deasserts.
  - `rng_get_next_val` follows `in_valid`.
- Reset mid-operation discards in-flight operands. No partial output is produced.

## Structure
- Package `sr_pkg`:
  - `sr_s1_t` struct (sign, exp, kept, inc, inexact, special).
  - `sr_res_t` output struct.
  - Helper functions `exp_all_ones(EXP_W)` and `round_inc`.
- One natural sub-module, `sr_pipe_reg`: a parameterized valid/ready register slice, instantiated twice (S1, S2).
- The rounding arithmetic stays inline in `sr_round_unit`.

## Test plan
Parameters are at their defaults. The bench drives `rng_val` from a model and counts `rng_get_next_val` pulses.
- Increment threshold: `exp=0x40`, `kept=0x800000`, `rbits=0x80`, lower bits 0.
  - `rng=0x7F` -> `mant=0x800000`, `inexact=1`.
  - `rng=0x80` -> `mant=0x800001`.
- Mantissa carry: `exp=0x10`, `kept=0xFFFFFF`, `rbits=0xFF`, `rng=0x01` -> `mant=0x800000`, `exp=0x11`, `overflow=0`.
- Exponent overflow: `exp=0xFE`, `kept=0xFFFFFF`, `rbits=0xFF`, `rng=0xFF` -> `exp=0xFF`, `mant=0`, `overflow=1`.
- Exact input and subnormal promotion:
  - Discarded bits 0, `rng=0xFF` -> no increment, `inexact=0`.
  - `exp=0`, `kept=0x7FFFFF`, `rbits=0xFF`, `rng=0x01` -> `exp=1`, `mant=0x800000`.
- NaN pass-through: `exp=0xFF`, `kept=0xC00000` -> output unchanged, exactly 1 RNG pulse.
- Backpressure and reset:
  - Send 6 back-to-back operands with `out_ready` low for 5 cycles -> `in_ready` low after 2 are held, outputs in order, RNG pulses = 6.
  - Assert `resetn` low with 2 operands in flight -> `out_valid=0`, no stale output afterwards.
